// File: rtl/blink_pkg.sv
// Shared types and width helpers for the blink scheduler.
package blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } blink_state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = (n <= 32'd1) ? 32'd1 : int'($clog2(n));
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot round-robin select; search starts one past ptr_i.
module rr_arbiter
  import blink_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = cnt_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Walk the requesters in rotated order and keep the first valid one.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((32'(ptr_i) + 32'd1 + k) % NUM_REQ);
      if (!found && req_valid_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/blink_scheduler.sv
// Round-robin time-sharing of one LED between NUM_REQ blink-burst requesters.
// Optional BLINK_SCHED_ABORT_EN adds an abort input that cuts a burst short.
module blink_scheduler
  import blink_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned GAP_TICKS = 2,
  localparam int unsigned IDX_W    = cnt_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*CNT_W-1:0] req_count,
`ifdef BLINK_SCHED_ABORT_EN
  input  logic                     abort,
`endif
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     q,
  output logic                     busy,
  output logic [IDX_W-1:0]         grant_id,
  output logic                     done
);

  localparam int unsigned PRESC_W = cnt_width(CLK_DIV);
  localparam int unsigned GAP_W   = cnt_width(GAP_TICKS + 1);

  blink_state_t        state_q;
  logic [PRESC_W-1:0]  presc_q;
  logic [PRESC_W-1:0]  presc_d;
  logic [CNT_W-1:0]    remaining_q;
  logic [GAP_W-1:0]    gap_q;
  logic [IDX_W-1:0]    last_grant_q;
  logic [IDX_W-1:0]    grant_id_q;
  logic                q_q;
  logic                busy_q;
  logic                done_q;

  logic                tick;
  logic                abort_c;
  logic [NUM_REQ-1:0]  gnt;
  logic                hs;
  logic [IDX_W-1:0]    hs_idx;
  logic [CNT_W-1:0]    hs_count;

`ifdef BLINK_SCHED_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_valid_i (req_valid),
    .ptr_i       (last_grant_q),
    .gnt_o       (gnt)
  );

  // Grants are only offered while idle and out of reset.
  assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;
  assign hs        = |(req_valid & req_ready);

  always_comb begin
    hs_idx   = '0;
    hs_count = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        hs_idx   = IDX_W'(i);
        hs_count = req_count[i*CNT_W +: CNT_W];
      end
    end
  end

  assign tick    = (presc_q == PRESC_W'(CLK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PRESC_W'(1);

  // Burst FSM; prescaler restarts on handshake and on abort so phases stay tick-aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      remaining_q  <= '0;
      gap_q        <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      q_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      presc_q <= presc_d;
      case (state_q)
        IDLE: begin
          if (hs) begin
            presc_q      <= '0;
            grant_id_q   <= hs_idx;
            last_grant_q <= hs_idx;
            remaining_q  <= hs_count;
            if (hs_count != '0) begin
              state_q <= ON;
              q_q     <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ON: begin
          if (abort_c) begin
            state_q <= GAP;
            q_q     <= 1'b0;
            gap_q   <= GAP_W'(GAP_TICKS);
            presc_q <= '0;
          end else if (tick) begin
            remaining_q <= remaining_q - CNT_W'(1);
            q_q         <= 1'b0;
            if (remaining_q > CNT_W'(1)) begin
              state_q <= OFF;
            end else begin
              state_q <= GAP;
              gap_q   <= GAP_W'(GAP_TICKS);
            end
          end
        end
        OFF: begin
          if (abort_c) begin
            state_q <= GAP;
            q_q     <= 1'b0;
            gap_q   <= GAP_W'(GAP_TICKS);
            presc_q <= '0;
          end else if (tick) begin
            state_q <= ON;
            q_q     <= 1'b1;
          end
        end
        GAP: begin
          if (tick) begin
            if (gap_q <= GAP_W'(1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              gap_q <= gap_q - GAP_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          q_q     <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q        = q_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;
  assign done     = done_q;

endmodule
